ddfs_sweep_ctrl: RTL

DDFS_SWEEP_CTRL -- requirements
Module: ddfs_sweep_ctrl

---
 rtl/ddfs_sweep_ctrl_if.sv | 32 +++
 rtl/ddfs_sweep_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ddfs_sweep_ctrl_if.sv
// Sweep-controller bundle: configuration handshake, run control and the FCW output side.
// The master drives configuration and control; the slave is the sweep controller.
interface ddfs_sweep_ctrl_if #(
  parameter int NBIT    = 16,
  parameter int DWELL_W = 16
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [NBIT-1:0]    cfg_f_start;
  logic [NBIT-1:0]    cfg_f_stop;
  logic [NBIT-1:0]    cfg_f_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               cfg_cont;
  logic               start;
  logic               abort;
  logic [NBIT-1:0]    fcw;
  logic               busy;
  logic               step_strobe;
  logic               done;

  modport master (
    output cfg_valid, cfg_f_start, cfg_f_stop, cfg_f_step, cfg_dwell, cfg_cont,
    output start, abort,
    input  cfg_ready, fcw, busy, step_strobe, done
  );

  modport slave (
    input  cfg_valid, cfg_f_start, cfg_f_stop, cfg_f_step, cfg_dwell, cfg_cont,
    input  start, abort,
    output cfg_ready, fcw, busy, step_strobe, done
  );
endinterface

// File: rtl/ddfs_sweep_ctrl.sv
// DDFS frequency sweep controller: steps the phase-accumulator increment (FCW)
// from a start to a stop value, holding each value for a programmable dwell.
module ddfs_sweep_ctrl #(
  parameter int NBIT    = 16,
  parameter int DWELL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  ddfs_sweep_ctrl_if.slave  bus
);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e             state_q;
  logic [NBIT-1:0]    fcw_q;
  logic               busy_q;
  logic               stepStrobe_q;
  logic               done_q;

  logic [NBIT-1:0]    cfgStart_q;
  logic [NBIT-1:0]    cfgStop_q;
  logic [NBIT-1:0]    cfgStep_q;
  logic [DWELL_W-1:0] cfgDwell_q;
  logic               cfgCont_q;
  logic               cfgUp_q;
  logic [DWELL_W-1:0] dwellCnt_q;

  logic               capture;
  logic [NBIT-1:0]    cfgStart_d;
  logic [NBIT-1:0]    cfgStop_d;
  logic [NBIT-1:0]    cfgStep_d;
  logic [DWELL_W-1:0] cfgDwell_d;
  logic               cfgCont_d;
  logic               cfgUp_d;

  logic [NBIT:0]      sum;
  logic [NBIT:0]      diff;
  logic [NBIT-1:0]    fcw_d;
  logic               atEnd;
  logic               dwellExpired;

  assign capture = (state_q == IDLE) && bus.cfg_valid;

  // The _d config is what is latched after this edge, so a start in the capture cycle already sees it.
  always_comb begin
    cfgStart_d = cfgStart_q;
    cfgStop_d  = cfgStop_q;
    cfgStep_d  = cfgStep_q;
    cfgDwell_d = cfgDwell_q;
    cfgCont_d  = cfgCont_q;
    cfgUp_d    = cfgUp_q;
    if (capture) begin
      cfgStart_d = bus.cfg_f_start;
      cfgStop_d  = bus.cfg_f_stop;
      cfgStep_d  = bus.cfg_f_step;
      cfgDwell_d = (bus.cfg_dwell == '0) ? DWELL_W'(1) : bus.cfg_dwell;
      cfgCont_d  = bus.cfg_cont;
      cfgUp_d    = (bus.cfg_f_start <= bus.cfg_f_stop);
    end
  end

  // The extra top bit of sum/diff flags overflow/underflow, which also clamps to stop.
  always_comb begin
    sum  = {1'b0, fcw_q} + {1'b0, cfgStep_q};
    diff = {1'b0, fcw_q} - {1'b0, cfgStep_q};
    if (cfgUp_q) begin
      fcw_d = (sum[NBIT] || (sum[NBIT-1:0] > cfgStop_q)) ? cfgStop_q : sum[NBIT-1:0];
    end else begin
      fcw_d = (diff[NBIT] || (diff[NBIT-1:0] < cfgStop_q)) ? cfgStop_q : diff[NBIT-1:0];
    end
    atEnd        = (fcw_q == cfgStop_q) || (cfgStep_q == '0);
    dwellExpired = (dwellCnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fcw_q        <= '0;
      busy_q       <= 1'b0;
      stepStrobe_q <= 1'b0;
      done_q       <= 1'b0;
      cfgStart_q   <= '0;
      cfgStop_q    <= '0;
      cfgStep_q    <= '0;
      cfgDwell_q   <= DWELL_W'(1);
      cfgCont_q    <= 1'b0;
      cfgUp_q      <= 1'b0;
      dwellCnt_q   <= '0;
    end else begin
      stepStrobe_q <= 1'b0;
      done_q       <= 1'b0;
      cfgStart_q   <= cfgStart_d;
      cfgStop_q    <= cfgStop_d;
      cfgStep_q    <= cfgStep_d;
      cfgDwell_q   <= cfgDwell_d;
      cfgCont_q    <= cfgCont_d;
      cfgUp_q      <= cfgUp_d;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q      <= RUN;
            fcw_q        <= cfgStart_d;
            busy_q       <= 1'b1;
            stepStrobe_q <= 1'b1;
            dwellCnt_q   <= cfgDwell_d - DWELL_W'(1);
          end
        end
        RUN: begin
          // The dwell counter holds the remaining cycles after the current one.
          if (bus.abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (!dwellExpired) begin
            dwellCnt_q <= dwellCnt_q - DWELL_W'(1);
          end else if (atEnd) begin
            if (cfgCont_q) begin
              fcw_q        <= cfgStart_q;
              stepStrobe_q <= 1'b1;
              dwellCnt_q   <= cfgDwell_q - DWELL_W'(1);
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            fcw_q        <= fcw_d;
            stepStrobe_q <= 1'b1;
            dwellCnt_q   <= cfgDwell_q - DWELL_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cfg_ready   = (state_q == IDLE);
  assign bus.fcw         = fcw_q;
  assign bus.busy        = busy_q;
  assign bus.step_strobe = stepStrobe_q;
  assign bus.done        = done_q;

endmodule
